jk_latch_writer: RTL and testbench
==================================

# jk_latch_writer

Write-side controller for a WIDTH-bit bank of level-sensitive JK latches. It accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the latch outputs. It then issues an enable strobe of programmable width, reads the latches back, and reports done or mismatch. It sits between synchronous register logic and the JK latch storage array; it never drives J=K=1, so latch race-around cannot occur.

## Interface
- WIDTH, 8: number of latch bits driven.
- STROBE_CYC, 2: cycles `en` is held high per write attempt (>=1).
- MAX_RETRY, 2: extra write attempts after a readback mismatch (0..7).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  write request valid.
- req_data  in  WIDTH  target word.
- req_ready  out  1  controller can accept a request.
- q  in  WIDTH  latch outputs (readback).
- j  out  WIDTH  latch J inputs.
- k  out  WIDTH  latch K inputs.
- en  out  1  latch enable strobe.
- done  out  1  one-cycle pulse: write finished, q matched.
- err  out  1  one-cycle pulse: retries exhausted, q mismatched.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, CHECK.
- IDLE: req_ready=1. On req_valid&req_ready, capture req_data into target, clear retry count, go SETUP.
- SETUP (1 cycle): compute per bit from sampled q and target, registered onto j/k: q=0,t=0 -> j=0,k=0; q=0,t=1 -> j=1,k=0; q=1,t=1 -> j=0,k=0; q=1,t=0 -> j=0,k=1. en=0. Go STROBE.
- STROBE: en=1 for exactly STROBE_CYC cycles (down-counter), j/k held constant. Go HOLD.
- HOLD (1 cycle): en=0, j/k still held (data stable across falling enable). Go CHECK.
- CHECK (1 cycle): j=k=0. If q==target: done=1, go IDLE. Else if retry<MAX_RETRY: retry++, go SETUP. Else err=1, go IDLE.
- j&k is 0 on every bit in every cycle (invariant).
- req_data/req_valid are ignored outside IDLE; target is not affected by later input changes.
- Bits already at target get j=k=0 (hold); only differing bits are excited.

## Timing
- Reset (async assert, sync to clk on deassert): state=IDLE, j=0, k=0, en=0, done=0, err=0, req_ready=1, target=0, counters=0.
- All outputs registered; no combinational path input->output.
- Successful single attempt: accept edge N -> SETUP N+1 -> en high N+2..N+1+STROBE_CYC -> HOLD -> CHECK; done pulses in CHECK, i.e. latency 4+STROBE_CYC cycles from accept; req_ready returns 1 the next cycle.
- Each retry adds 3+STROBE_CYC cycles.
- Back-to-back: a request held valid while done pulses is accepted in the first IDLE cycle after done.
- Reset mid-operation: en, j, k drop to 0 immediately (async); no done/err issued for the aborted request.
- Write of a word equal to current q: still runs full sequence with j=k=0 all bits; done pulses, en still strobes.
- q sampled only in SETUP and CHECK; glitches elsewhere are ignored.

## Test plan
- Reset: assert rst_n=0 mid-STROBE -> en, j, k go 0 without a clock; after release req_ready=1, done=err=0.
- Basic write, WIDTH=8, STROBE_CYC=2, latch model initialised to 0x00, write 0xA5 -> j=0xA5, k=0x00, en high exactly 2 cycles, q=0xA5, done at accept+6.
- Mixed excitation: q=0xF0, write 0x3C -> j=0x0C, k=0xC0, done, q=0x3C; check j&k==0 every cycle.
- Retry: latch model ignores the first en pulse, write 0x01 -> one retry, done at accept+11, no err.
- Exhaust: latch bit 7 stuck at 0, MAX_RETRY=2, write 0x80 -> 3 strobes, err pulses once, done never, back to IDLE.
- Handshake: req_valid held high for two words 0x11, 0x22 -> second accepted only after first done; req_data changes during busy do not alter j/k.

Source files
------------

// File: rtl/jk_latch_writer.sv
// Write-side controller for a bank of level-sensitive JK latches: computes J/K
// excitation from readback, strobes the enable, verifies and retries on mismatch.
module jk_latch_writer #(
    parameter int WIDTH      = 8,
    parameter int STROBE_CYC = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             en,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam int         CW        = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYC - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    logic [2:0]       state, next_state;
    logic [WIDTH-1:0] target;
    logic [CW-1:0]    strobe_cnt;
    logic [2:0]       retry_cnt;
    logic             match;

    assign match = (q == target);

    // NOTE: every branch falls back to the default assigned first, so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (req_valid) next_state = S_SETUP;
            S_SETUP:  next_state = S_STROBE;
            S_STROBE: if (strobe_cnt == '0) next_state = S_HOLD;
            S_HOLD:   next_state = S_CHECK;
            S_CHECK: begin
                if (match)                      next_state = S_IDLE;
                else if (retry_cnt < RETRY_MAX) next_state = S_SETUP;
                else                            next_state = S_IDLE;
            end
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            target     <= '0;
            strobe_cnt <= '0;
            retry_cnt  <= '0;
            j          <= '0;
            k          <= '0;
            en         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= (next_state == S_IDLE);
            en        <= (next_state == S_STROBE);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        target    <= req_data;
                        retry_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    // J and K are disjoint by construction: a bit is set or cleared, never toggled.
                    j          <= target & ~q;
                    k          <= ~target & q;
                    strobe_cnt <= STROBE_LOAD;
                end
                S_STROBE: begin
                    if (strobe_cnt != '0) strobe_cnt <= strobe_cnt - 1'b1;
                end
                S_HOLD: begin
                    j <= '0;
                    k <= '0;
                end
                S_CHECK: begin
                    if (match)                      done      <= 1'b1;
                    else if (retry_cnt < RETRY_MAX) retry_cnt <= retry_cnt + 3'd1;
                    else                            err       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_latch_writer.sv
// Self-checking bench for jk_latch_writer: behavioural JK latch bank, scoreboard of
// expected completions, per-cycle excitation and strobe-width monitoring.
module tb_jk_latch_writer;

    localparam int WIDTH      = 8;
    localparam int STROBE_CYC = 2;
    localparam int MAX_RETRY  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    logic [WIDTH-1:0] latch_q = '0;
    logic [WIDTH-1:0] j, k;
    logic             en, done, err;

    jk_latch_writer #(.WIDTH(WIDTH), .STROBE_CYC(STROBE_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .q(latch_q), .j(j), .k(k), .en(en), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        bit               exp_err;
        int               attempts;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Latch bank model: Q+ = J&~Q | ~K&Q while enabled, with skip and stuck-bit faults.
    logic             preset = 1'b0;
    logic [WIDTH-1:0] preset_val = '0;
    int               preset_skip = 0;
    bit               stuck7 = 1'b0;
    int               skip_cnt = 0;
    bit               en_seen = 1'b0;
    logic [WIDTH-1:0] stuck_mask;
    assign stuck_mask = stuck7 ? 8'h80 : 8'h00;

    always @(posedge clk) begin
        if (preset) begin
            latch_q  <= preset_val & ~stuck_mask;
            skip_cnt <= preset_skip;
            en_seen  <= 1'b0;
        end else if (en) begin
            en_seen <= 1'b1;
            if (skip_cnt == 0) latch_q <= ((j & ~latch_q) | (~k & latch_q)) & ~stuck_mask;
        end else if (en_seen) begin
            en_seen <= 1'b0;
            if (skip_cnt > 0) skip_cnt <= skip_cnt - 1;
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [WIDTH-1:0] first_j, first_k, rise_j, rise_k;
    initial begin
        int   en_run    = 0;
        bit   en_d      = 1'b0;
        bit   post_hold = 1'b0;
        int   strobes   = 0;
        exp_t e;
        int   a;
        first_j = '0; first_k = '0; rise_j = '0; rise_k = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_run = 0; en_d = 1'b0; post_hold = 1'b0; strobes = 0;
                sb.delete(); acc_q.delete();
            end else begin
                check("j_and_k_overlap", 32'(j & k), 32'd0);
                if (req_valid && req_ready) acc_q.push_back(cyc);
                if (post_hold) begin
                    check("check_j_zero", 32'(j), 32'd0);
                    check("check_k_zero", 32'(k), 32'd0);
                    post_hold = 1'b0;
                end
                if (en) begin
                    en_run++;
                    if (!en_d) begin
                        strobes++;
                        rise_j = j; rise_k = k;
                        if (strobes == 1) begin first_j = j; first_k = k; end
                        if (sb.size() > 0) begin
                            check("j_excite", 32'(j), 32'(sb[0].data & ~latch_q));
                            check("k_excite", 32'(k), 32'(~sb[0].data & latch_q));
                        end else begin
                            check("strobe_without_request", 32'd1, 32'd0);
                        end
                    end
                end else if (en_d) begin
                    check("en_width", 32'(en_run), 32'(STROBE_CYC));
                    check("hold_j", 32'(j), 32'(rise_j));
                    check("hold_k", 32'(k), 32'(rise_k));
                    en_run    = 0;
                    post_hold = 1'b1;
                end
                en_d = en;
                if (done || err) begin
                    if (sb.size() == 0 || acc_q.size() == 0) begin
                        check("unexpected_done_err", {30'd0, done, err}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        a = acc_q.pop_front();
                        check("done_flag", 32'(done), 32'(!e.exp_err));
                        check("err_flag", 32'(err), 32'(e.exp_err));
                        check("latency", 32'(cyc - a),
                              32'(4 + STROBE_CYC + (e.attempts - 1) * (3 + STROBE_CYC)));
                        check("strobe_count", 32'(strobes), 32'(e.attempts));
                        if (!e.exp_err) check("readback", 32'(latch_q), 32'(e.data));
                    end
                    strobes = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preset_latch(input logic [WIDTH-1:0] v, input int skip);
        preset_val  = v;
        preset_skip = skip;
        preset      = 1'b1;
        tick();
        preset      = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (req_ready) break;
            tick();
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit e, input int n);
        sb.push_back('{data: d, exp_err: e, attempts: n});
        req_data  = d;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
        req_data  = ~d;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && req_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] r;
        bit               seen;
        rst_n = 1'b0; req_valid = 1'b0; req_data = '0;
        #12;
        check("rst_en", 32'(en), 32'd0);
        check("rst_j", 32'(j), 32'd0);
        check("rst_k", 32'(k), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic write from all-zero latches.
        preset_latch(8'h00, 0);
        send(8'hA5, 1'b0, 1);
        wait_idle();
        check("basic_j", 32'(first_j), 32'hA5);
        check("basic_k", 32'(first_k), 32'h00);
        check("basic_q", 32'(latch_q), 32'hA5);

        // Mixed set/clear excitation.
        preset_latch(8'hF0, 0);
        send(8'h3C, 1'b0, 1);
        wait_idle();
        check("mixed_j", 32'(first_j), 32'h0C);
        check("mixed_k", 32'(first_k), 32'hC0);
        check("mixed_q", 32'(latch_q), 32'h3C);

        // Writing the value already held still strobes with no excitation.
        send(8'h3C, 1'b0, 1);
        wait_idle();
        check("same_j", 32'(first_j), 32'h00);
        check("same_k", 32'(first_k), 32'h00);

        // First enable pulse ignored by the latches: one retry.
        preset_latch(8'h00, 1);
        send(8'h01, 1'b0, 2);
        wait_idle();
        check("retry_q", 32'(latch_q), 32'h01);

        // Bit 7 stuck low: all attempts fail.
        stuck7 = 1'b1;
        preset_latch(8'h00, 0);
        send(8'h80, 1'b1, MAX_RETRY + 1);
        wait_idle();
        check("exhaust_q", 32'(latch_q), 32'h00);
        check("exhaust_ready", 32'(req_ready), 32'd1);
        stuck7 = 1'b0;

        // Back-to-back with req_valid held; data changes while busy.
        preset_latch(8'h00, 0);
        sb.push_back('{data: 8'h11, exp_err: 1'b0, attempts: 1});
        sb.push_back('{data: 8'h22, exp_err: 1'b0, attempts: 1});
        req_data  = 8'h11;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_data = 8'h22;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        check("b2b_first_done", 32'(seen), 32'd1);
        check("b2b_ready_with_done", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_data  = 8'hFF;
        wait_idle();
        check("b2b_q", 32'(latch_q), 32'h22);

        // A few random words.
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r, 1'b0, 1);
            wait_idle();
            check("rand_q", 32'(latch_q), 32'(r));
        end

        // Reset during the strobe.
        preset_latch(8'h00, 0);
        sb.push_back('{data: 8'h5A, exp_err: 1'b0, attempts: 1});
        req_data  = 8'h5A;
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (en) break;
            tick();
        end
        check("pre_reset_en", 32'(en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_en", 32'(en), 32'd0);
        check("async_j", 32'(j), 32'd0);
        check("async_k", 32'(k), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) tick();

        // Recovery after the aborted write.
        preset_latch(8'h0F, 0);
        send(8'hC3, 1'b0, 1);
        wait_idle();
        check("recover_j", 32'(first_j), 32'hC0);
        check("recover_k", 32'(first_k), 32'h0C);
        check("recover_q", 32'(latch_q), 32'hC3);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
